imem_writer: RTL and testbench

- Writes a stream of 32-bit instruction words into the byte-wide instruction memory array.
- Byte order is big-endian: the word's MSB goes to the lowest address, so a later 4-byte read at the same address returns the original word.
- Used at boot or in test benches to program instruction memory from a host or loader.
- Serialises each accepted word into four consecutive byte writes.

---
 rtl/imem_writer.sv | 137 +++++++++++++
 tb/tb_imem_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_writer.sv
// Serialises 32-bit instruction words into big-endian byte writes for a byte-wide instruction memory.
// Optional bounds checking (suppressed out-of-range writes + sticky err) is enabled by IMEM_WRITER_BOUNDS_CHECK_EN.
module imem_writer #(
  parameter int IMEM_SIZE = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  output logic             in_ready,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
  output logic             err,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [63:0]      r_ptr;
  logic [63:0]      r_last_addr;
  logic [CNT_W-1:0] r_rem;
  logic [1:0]       r_idx;
  logic [31:0]      r_word;
  logic [7:0]       r_last_data;
  logic [7:0]       w_byte;
  logic             w_in_range;
  logic             w_start_ok;

  assign w_start_ok = start && (r_state == S_IDLE);

`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
  assign w_in_range = (r_ptr < 64'(IMEM_SIZE));
`else
  logic w_unused_size;
  assign w_unused_size = (IMEM_SIZE > 0);
  assign w_in_range    = 1'b1;
`endif

  // Big-endian: byte index 0 carries the most significant byte.
  always_comb begin
    case (r_idx)
      2'd0:    w_byte = r_word[31:24];
      2'd1:    w_byte = r_word[23:16];
      2'd2:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_last_addr;
    mem_wdata = r_last_data;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (word_count == '0) ? S_DONE : S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we    = w_in_range;
        mem_addr  = r_ptr;
        mem_wdata = w_byte;
        if (r_idx == 2'd3) w_next = (r_rem == CNT_W'(1)) ? S_DONE : S_ACCEPT;
      end
      default: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: datapath registers are reset too, so the held mem_addr/mem_wdata read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      if (w_start_ok) begin
        r_ptr <= base_addr;
        r_rem <= word_count;
      end
      if ((r_state == S_ACCEPT) && in_valid) begin
        r_word <= in_word;
        r_idx  <= 2'd0;
      end
      if (r_state == S_WRITE) begin
        r_ptr       <= r_ptr + 64'd1;
        r_idx       <= r_idx + 2'd1;
        r_last_addr <= r_ptr;
        r_last_data <= w_byte;
        if (r_idx == 2'd3) r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
  // Sticky until reset or the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err <= 1'b0;
    else if (w_start_ok)                          err <= 1'b0;
    else if ((r_state == S_WRITE) && !w_in_range) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_imem_writer.sv
// Randomised self-checking bench for imem_writer: a byte-stream model derived from the word list
// is compared against every memory write, plus latency, hold, reset and ignored-start checks.
module tb_imem_writer;
  localparam int IMEM_SIZE = 4096;
  localparam int CNT_W     = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [63:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_word;
  logic             in_ready;
  logic             mem_we;
  logic [63:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             busy;
  logic             done;
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
  logic             err;
`endif

  imem_writer #(.IMEM_SIZE(IMEM_SIZE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
    .err        (err),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit oob(input logic [63:0] a);
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
    return a >= 64'(IMEM_SIZE);
`else
    return (a != a);
`endif
  endfunction

  logic [31:0] words[$];

  task automatic fill_words(input int n);
    words.delete();
    repeat (n) words.push_back($urandom);
  endtask

  // One complete load: build the expected byte stream from the word list, then drive and score.
  task automatic run_load(input logic [63:0] base, input int n, input int max_gap, input bit restart_mid);
    logic [63:0] ea[$];
    logic [7:0]  ed[$];
    logic [63:0] a;
    logic [63:0] final_addr;
    logic [7:0]  final_data;
    bit          exp_err;
    bit          done_seen;
    bit          last_in_range;
    int          cyc, gap, last_we, done_cyc, budget;

    exp_err = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        a = base + 64'(4 * k + j);
        if (oob(a)) exp_err = 1'b1;
        else begin
          ea.push_back(a);
          ed.push_back(words[k][31 - 8 * j -: 8]);
        end
      end
    end
    final_addr    = base + 64'(4 * n - 1);
    final_data    = (n > 0) ? words[n-1][7:0] : 8'h00;
    last_in_range = !oob(final_addr);

    base_addr  = base;
    word_count = CNT_W'(n);
    in_valid   = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    gap       = $urandom_range(max_gap, 0);
    done_seen = 1'b0;
    last_we   = -1;
    done_cyc  = -1;
    budget    = 5 * n + n * max_gap + 20;

    while (!done_seen && cyc < budget) begin
      if (mem_we) begin
        if (ea.size() == 0) check("unexpected_write", {63'b0, mem_we}, 64'd0);
        else begin
          check("wr_addr", mem_addr, ea.pop_front());
          check("wr_data", {56'b0, mem_wdata}, {56'b0, ed.pop_front()});
        end
        check("ready_in_write", {63'b0, in_ready}, 64'd0);
        last_we = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else if (words.size() > 0) begin
        in_valid = 1'b1;
        in_word  = words[0];
        if (in_ready) begin
          void'(words.pop_front());
          gap = $urandom_range(max_gap, 0);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (restart_mid) begin
        if (cyc == 3) begin
          start      = 1'b1;
          base_addr  = {$urandom, $urandom};
          word_count = CNT_W'($urandom_range(9, 1));
        end else begin
          start = 1'b0;
        end
      end
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;

    check("done_seen", {63'b0, done_seen}, 64'd1);
    check("writes_left", 64'(ea.size()), 64'd0);
    if (n == 0)                check("zero_latency", 64'(done_cyc), 64'd1);
    else if (max_gap == 0)     check("latency", 64'(done_cyc), 64'(5 * n + 1));
    else if (last_in_range)    check("done_after_last", 64'(done_cyc), 64'(last_we + 1));
    if (n > 0) begin
      check("hold_addr", mem_addr, final_addr);
      check("hold_data", {56'b0, mem_wdata}, {56'b0, final_data});
    end
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
    check("err", {63'b0, err}, {63'b0, exp_err});
`endif
    @(negedge clk);
    check("done_pulse_len", {63'b0, done}, 64'd0);
    check("busy_idle", {63'b0, busy}, 64'd0);
    check("ready_idle", {63'b0, in_ready}, 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {63'b0, in_ready}, 64'd0);
    check({tag, "_we"},    {63'b0, mem_we},   64'd0);
    check({tag, "_busy"},  {63'b0, busy},     64'd0);
    check({tag, "_done"},  {63'b0, done},     64'd0);
  endtask

  initial begin
    logic [63:0] rbase;
    int          rn;

    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_word    = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_addr", mem_addr, 64'd0);
    check("reset_data", {56'b0, mem_wdata}, 64'd0);
`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
    check("reset_err", {63'b0, err}, 64'd0);
`endif
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("idle_no_start");
    end
    in_valid = 1'b0;

    words.delete();
    words.push_back(32'hDEADBEEF);
    run_load(64'h10, 1, 0, 1'b0);

    fill_words(3);
    run_load(64'h100, 3, 5, 1'b0);

    words.delete();
    run_load(64'h40, 0, 0, 1'b0);

    fill_words(2);
    run_load(64'h200, 2, 2, 1'b1);

    fill_words(1);
    run_load(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1'b0);

`ifdef IMEM_WRITER_BOUNDS_CHECK_EN
    fill_words(1);
    run_load(64'd4094, 1, 0, 1'b0);
`endif

    repeat (12) begin
      rn    = $urandom_range(5, 0);
      rbase = ($urandom_range(1, 0) == 1) ? 64'($urandom_range(4000, 0)) : {$urandom, $urandom};
      fill_words(rn);
      run_load(rbase, rn, $urandom_range(4, 0), 1'b0);
    end

    // Reset in the middle of a write burst.
    base_addr  = 64'h300;
    word_count = CNT_W'(2);
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = $urandom;
    for (int i = 0; i < 20 && !mem_we; i++) @(negedge clk);
    check("reach_write", {63'b0, mem_we}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    check("mid_reset_addr", mem_addr, 64'd0);
    check("mid_reset_data", {56'b0, mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("post_reset");
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
